// File: rtl/ovc_class_alloc_tracker.sv
// Output-VC ownership and credit tracker for one router output port.
// Masks VCs by message class, tracks FREE/BUSY and downstream credits per VC,
// and grants one permitted free VC per request using a round-robin pointer.
// Optional build macro: OVC_FULL_CREDIT_ALLOC_EN -- a VC is grantable only
// when its downstream buffer is fully drained (credit == B).
module ovc_class_alloc_tracker #(
    parameter int V = 4,
    parameter int C = 2,
    parameter int B = 4,
    parameter logic [((C > 1) ? C : 1)*V-1:0] CLASS_SETTING = '1,
    localparam int CW = (C > 1) ? $clog2(C) : 1,
    localparam int BW = $clog2(B + 1),
    localparam int PW = (V > 1) ? $clog2(V) : 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          req_valid_i,
    input  logic [CW-1:0] req_class_i,
    output logic          grant_valid_o,
    output logic [V-1:0]  grant_vc_o,
    input  logic [V-1:0]  release_vc_i,
    input  logic [V-1:0]  flit_sent_i,
    input  logic [V-1:0]  credit_in_i,
    output logic [V-1:0]  ovc_avail_o,
    output logic [V-1:0]  ovc_credit_ok_o,
    output logic          err_o
);

    logic [V-1:0]         busy_q, busy_d;
    logic [V-1:0][BW-1:0] cred_q, cred_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic [V-1:0]         avail_q, avail_d;
    logic [V-1:0]         credok_q, credok_d;

    logic [V-1:0]         mask, avail_int, cand, gnt_vc;
    logic [PW-1:0]        gnt_idx;
    logic                 found;

    // Class mask: out-of-range classes see an empty mask and never win.
    always_comb begin
        mask = '0;
        if (C <= 1) begin
            mask = '1;
        end else begin
            for (int c = 0; c < C; c++)
                if (int'(req_class_i) == c) mask = CLASS_SETTING[c*V +: V];
        end
    end

    // Grantability from current state; a VC released this cycle is still BUSY here.
    always_comb begin
        avail_int = '0;
        for (int i = 0; i < V; i++) begin
`ifdef OVC_FULL_CREDIT_ALLOC_EN
            avail_int[i] = ~busy_q[i] & (cred_q[i] == BW'(B));
`else
            avail_int[i] = ~busy_q[i] & (cred_q[i] != '0);
`endif
        end
        cand = mask & avail_int;
    end

    // Round-robin pick: first candidate at or circularly above the pointer.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_vc  = '0;
        gnt_idx = '0;
        for (int k = 0; k < V; k++) begin
            idx = (int'(ptr_q) + k) % V;
            if (!found && req_valid_i && cand[idx]) begin
                found       = 1'b1;
                gnt_vc[idx] = 1'b1;
                gnt_idx     = PW'(idx);
            end
        end
    end

    assign grant_valid_o = found;
    assign grant_vc_o    = gnt_vc;

    // Next state: ownership, pointer, saturating credits with sticky error.
    always_comb begin
        int nxt;
        busy_d = (busy_q & ~release_vc_i) | gnt_vc;
        nxt    = int'(gnt_idx) + 1;
        ptr_d  = found ? ((nxt == V) ? '0 : PW'(nxt)) : ptr_q;
        cred_d = cred_q;
        err_d  = err_q;
        for (int i = 0; i < V; i++) begin
            if (flit_sent_i[i] && !credit_in_i[i]) begin
                if (cred_q[i] == '0) err_d = 1'b1;
                else                 cred_d[i] = cred_q[i] - 1'b1;
            end else if (credit_in_i[i] && !flit_sent_i[i]) begin
                if (cred_q[i] == BW'(B)) err_d = 1'b1;
                else                     cred_d[i] = cred_q[i] + 1'b1;
            end
        end
        avail_d  = '0;
        credok_d = '0;
        for (int i = 0; i < V; i++) begin
`ifdef OVC_FULL_CREDIT_ALLOC_EN
            avail_d[i] = ~busy_d[i] & (cred_d[i] == BW'(B));
`else
            avail_d[i] = ~busy_d[i] & (cred_d[i] != '0);
`endif
            credok_d[i] = (cred_d[i] != '0);
        end
    end

    // State registers; reset abandons all ownership immediately.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q   <= '0;
            for (int i = 0; i < V; i++) cred_q[i] <= BW'(B);
            ptr_q    <= '0;
            err_q    <= 1'b0;
            avail_q  <= '1;
            credok_q <= '1;
        end else begin
            busy_q   <= busy_d;
            cred_q   <= cred_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            avail_q  <= avail_d;
            credok_q <= credok_d;
        end
    end

    assign ovc_avail_o     = avail_q;
    assign ovc_credit_ok_o = credok_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_ovc_class_alloc_tracker.sv
// Bench for ovc_class_alloc_tracker: directed steps plus randomized traffic,
// all compared against a behavioural model of VC ownership and credits.
module tb_ovc_class_alloc_tracker;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [0:0] req_class;
    logic       gv;
    logic [3:0] gvc, rel, fs, ci, avail, cok;
    logic       err;

    always #5 clk = ~clk;

    ovc_class_alloc_tracker #(
        .V(4), .C(2), .B(B), .CLASS_SETTING(8'b1100_0011)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_class_i(req_class),
        .grant_valid_o(gv), .grant_vc_o(gvc),
        .release_vc_i(rel), .flit_sent_i(fs), .credit_in_i(ci),
        .ovc_avail_o(avail), .ovc_credit_ok_o(cok), .err_o(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner flags, credit counts, rotation start, error flag.
    bit   m_busy [4];
    int   m_cred [4];
    int   m_ptr;
    bit   m_err;
    logic [3:0] cls_mask [2] = '{4'b0011, 4'b1100};

    logic [3:0] last_gvc, last_cok;
    logic       last_err;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_cred[i] = B; end
        m_ptr = 0;
        m_err = 0;
    endtask

    function automatic bit m_can(input int i);
`ifdef OVC_FULL_CREDIT_ALLOC_EN
        return !m_busy[i] && m_cred[i] == B;
`else
        return !m_busy[i] && m_cred[i] > 0;
`endif
    endfunction

    function automatic logic [3:0] m_avail();
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = m_can(i);
        return r;
    endfunction

    function automatic logic [3:0] m_cok();
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (m_cred[i] > 0);
        return r;
    endfunction

    // Index of the VC the model grants, or -1.
    function automatic int m_grant(input bit rv, input int cls);
        logic [3:0] m;
        if (!rv) return -1;
        m = cls_mask[cls];
        for (int k = 0; k < 4; k++) begin
            int j = (m_ptr + k) % 4;
            if (m[j] && m_can(j)) return j;
        end
        return -1;
    endfunction

    // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input bit rv, input int cls, input logic [3:0] r,
                        input logic [3:0] f, input logic [3:0] c);
        int g;
        logic [3:0] ev;
        req_valid = rv; req_class = 1'(cls); rel = r; fs = f; ci = c;
        g  = m_grant(rv, cls);
        ev = (g < 0) ? 4'b0 : 4'(1 << g);
        @(negedge clk);
        chk("grant_valid", gv, (g >= 0));
        chk("grant_vc", gvc, ev);
        chk("ovc_avail", avail, m_avail());
        chk("ovc_credit_ok", cok, m_cok());
        chk("err", err, m_err);
        last_gvc = gvc; last_cok = cok; last_err = err;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (r[i] && m_busy[i]) m_busy[i] = 0;
        if (g >= 0) begin m_busy[g] = 1; m_ptr = (g + 1) % 4; end
        for (int i = 0; i < 4; i++) begin
            if (f[i] && !c[i]) begin
                if (m_cred[i] == 0) m_err = 1; else m_cred[i]--;
            end else if (c[i] && !f[i]) begin
                if (m_cred[i] == B) m_err = 1; else m_cred[i]++;
            end
        end
        #1;
    endtask

    initial begin
        int ncred0;
        reset_n = 1'b0; req_valid = 0; req_class = 0; rel = 0; fs = 0; ci = 0;
        m_reset();
        #12;
        chk("rst_grant_valid", gv, 1'b0);
        chk("rst_grant_vc", gvc, 4'b0000);
        chk("rst_avail", avail, 4'b1111);
        chk("rst_credit_ok", cok, 4'b1111);
        chk("rst_err", err, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Class 1 may use VC2/VC3 only.
        step(1, 1, 0, 0, 0); chk("dir_c1_first", last_gvc, 4'b0100);
        step(1, 1, 0, 0, 0); chk("dir_c1_second", last_gvc, 4'b1000);
        step(1, 1, 0, 0, 0); chk("dir_c1_none", last_gvc, 4'b0000);
        // Class 0 fills VC0/VC1; released VC not grantable in release cycle.
        step(1, 0, 0, 0, 0); chk("dir_c0_first", last_gvc, 4'b0001);
        step(1, 0, 0, 0, 0); chk("dir_c0_second", last_gvc, 4'b0010);
        step(1, 0, 4'b0001, 0, 0); chk("dir_rel_same_cycle", last_gvc, 4'b0000);
        step(1, 0, 0, 0, 0); chk("dir_rel_next_cycle", last_gvc, 4'b0001);
        step(0, 0, 4'b1111, 0, 0);

        // Drain VC0 and VC1 credits; class 0 then cannot be granted.
        for (int k = 0; k < 4; k++) step(0, 0, 0, 4'b0001, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 4'b0010, 0);
        step(1, 0, 0, 0, 0);
        chk("dir_credit_ok_drained", last_cok, 4'b1100);
        chk("dir_no_grant_drained", last_gvc, 4'b0000);
`ifdef OVC_FULL_CREDIT_ALLOC_EN
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 4'b0001);
        step(1, 0, 0, 0, 0); chk("dir_partial_credit_no_grant", last_gvc, 4'b0000);
        step(0, 0, 0, 0, 4'b0001);
        ncred0 = 0;
`else
        step(0, 0, 0, 0, 4'b0001);
        ncred0 = 3;
`endif
        step(1, 0, 0, 0, 0); chk("dir_credit_restores_grant", last_gvc, 4'b0001);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, {2'b00, 1'b1, 1'(k < ncred0)});
        step(0, 0, 4'b1111, 0, 0);

        // Simultaneous send/return at B is neutral; a lone return at B is an error.
        step(0, 0, 0, 4'b0100, 4'b0100);
        step(0, 0, 0, 0, 0); chk("dir_err_neutral", last_err, 1'b0);
        step(0, 0, 0, 0, 4'b0100);
        step(0, 0, 0, 0, 0); chk("dir_err_set", last_err, 1'b1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        chk("dir_err_sticky", last_err, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r, f, c;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            f = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            c = 4'($urandom) & 4'($urandom);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 1), r, f, c);
        end

        // Occupy several VCs, then reset asynchronously mid-cycle.
        step(0, 0, 4'b1111, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 4'b1111);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #2;
        req_valid = 0;
        reset_n = 1'b0;
        #1;
        chk("arst_grant_valid", gv, 1'b0);
        chk("arst_grant_vc", gvc, 4'b0000);
        chk("arst_avail", avail, 4'b1111);
        chk("arst_credit_ok", cok, 4'b1111);
        chk("arst_err", err, 1'b0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0); chk("dir_after_reset_grant", last_gvc, 4'b0001);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ovc_class_alloc_tracker.md
Name: ovc_class_alloc_tracker

Overview:
- Per-output-port tracker for output-VC ownership and downstream credits.
- Replaces the static class-to-VC mask with a stateful allocator.
- Masks VCs by message class (CLASS_SETTING), tracks FREE/BUSY state and credit count for each output VC, and grants one permitted free VC per request using round-robin.
- Sits between the VC allocator and the output-port credit logic in the router.

Parameters:
- V, 4, number of output VCs
- C, 2, number of message classes; C<=1 means no class masking
- B, 4, downstream buffer depth per VC, in flits (initial and maximum credits)
- CLASS_SETTING, {(C*V){1'b1}}, packed class masks; bits [c*V+V-1 : c*V] are the VCs allowed for class c
- Derived: Cw = max(1, log2(C)); Bw = log2(B+1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  VC allocation request
- req_class  in  Cw  class of the requesting packet
- grant_valid  out  1  a VC was granted this cycle
- grant_vc  out  V  one-hot granted VC; all-zero when no grant
- release_vc  in  V  per-VC release (tail flit credit returned downstream)
- flit_sent  in  V  one-hot; a flit was sent on that VC, consumes one credit
- credit_in  in  V  per-VC credit return
- ovc_avail  out  V  registered; VC is FREE and grantable under the current rule
- ovc_credit_ok  out  V  registered; VC credit count > 0
- err  out  1  sticky flag for credit overflow/underflow

Behaviour:
- Reset (async, reset==0):
  - All VCs FREE; every credit counter = B; round-robin pointer = 0.
  - err = 0; ovc_avail = all ones; ovc_credit_ok = all ones.
  - grant_valid = 0 and grant_vc = 0 once req_valid is low.
  - Asserting reset mid-operation abandons all ownership immediately.
- Class mask:
  - mask = CLASS_SETTING[req_class*V +: V].
  - C<=1: mask = all ones.
  - req_class >= C: mask = 0, so no grant.
- Candidate set: cand = mask & ovc_avail_int, where ovc_avail_int[i] = FREE[i] & (credit[i] > 0).
- Grant (combinational, zero-cycle latency):
  - grant_valid = req_valid & |cand.
  - grant_vc = first set bit of cand, searching circularly from the pointer upward.
  - No candidate: grant_valid = 0 and the requester retries. There is no queueing.
- At the clock edge after a grant:
  - Granted VC becomes BUSY.
  - Pointer = (granted index + 1) mod V.
  - Pointer is unchanged when there is no grant.
- Release:
  - release_vc[i] on a BUSY VC -> FREE at the next edge.
  - A released VC is not grantable in the same cycle it is released.
  - Release of a FREE VC is ignored and does not set err.
  - Release and grant of different VCs in the same cycle are both honoured.
- Credits, per VC, at each edge:
  - flit_sent only: -1.
  - credit_in only: +1.
  - Both: unchanged.
  - Decrement at 0: hold 0, set err.
  - Increment at B: hold B, set err.
  - Credits are independent of FREE/BUSY state.
- err clears only on reset.
- ovc_avail and ovc_credit_ok are registered copies of the internal next-state values (one-cycle latency).
- Invariant: grant_vc is one-hot or zero and never selects a BUSY VC.

Optional Feature:
- Macro: OVC_FULL_CREDIT_ALLOC_EN.
- Defined: atomic VC allocation. ovc_avail_int[i] = FREE[i] & (credit[i] == B), so a VC is grantable only once the downstream buffer is fully drained.
- Undefined: the credit[i] > 0 rule above applies.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then V=4, C=2, CLASS_SETTING=8'b1100_0011, req_class=1, req_valid held 3 cycles, no releases -> grant_vc = 0100, then 1000, then grant_valid=0.
- Same setup, C=1, four back-to-back requests, then release_vc=0001 in cycle 5 and a request in cycle 5 and again in cycle 6:
  - grants 0001, 0010, 0100, 1000;
  - cycle 5 request gets no grant;
  - cycle 6 request gets 0001.
- Four flit_sent pulses on VC0 while FREE -> ovc_credit_ok[0]=0 one cycle after the fourth; a request restricted to VC0 is not granted; one credit_in restores the grant.
- flit_sent[2] and credit_in[2] in the same cycle at credit=B -> credit stays B, err stays 0; a further credit_in[2] alone -> err=1 and stays 1 until reset.
- reset pulsed low while 3 VCs are BUSY -> outputs reach reset values asynchronously; the next request grants 0001.
- OVC_FULL_CREDIT_ALLOC_EN defined: VC0 released with credit=3 -> not granted; after credit_in[0] raises credit to 4 -> granted.
